ahbif: RTL and testbench

AHBIF -- requirements
Module: ahbif

---
 rtl/ahbif.sv | 182 ++++++++++++++++++
 tb/tb_ahbif.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbif.sv
// rtl/ahbif.sv - AHB bus master interface: request/grant, burst generation, write/read data phases
//
// Turns a simple start/address/size/count request into an AHB burst. The
// address phase is driven from registered outputs; each accepted beat opens a
// data phase on the following cycle. Bursts that would cross a 1 KB boundary,
// or that resume after a grant loss, are issued as INCR.

module ahbif (
  input  logic        HCLK,
  input  logic        HRESETN_N,
  input  logic        I_START,
  input  logic [31:0] I_ADDR,
  input  logic [2:0]  I_SIZE,
  input  logic [4:0]  I_COUNT,
  input  logic        I_WRITE,
  input  logic [31:0] I_WDATA,
  input  logic        I_BUSY,
  input  logic        HGRANT,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        HBUSREQ,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic [31:0] O_RDATA
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA
  } state_t;

  state_t      state;
  logic [4:0]  beats_left;   // beats whose address has not yet been accepted
  logic        data_ph;      // current cycle is the data phase of an accepted beat

  logic [2:0]  req_size;
  logic [4:0]  req_count;
  logic [6:0]  req_bytes;
  logic        req_cross;
  logic [2:0]  req_burst;
  logic        beat_accepted;
  logic [31:0] step;
  logic [31:0] next_addr;
  logic [31:0] resume_addr;
  logic [1:0]  resume_trans;

  // Request decode: clamp size/count and pick the burst type, INCR when the span crosses 1 KB
  always_comb begin
    req_size  = (I_SIZE > 3'd2) ? 3'd2 : I_SIZE;
    req_count = (I_COUNT == 5'd0) ? 5'd1 : I_COUNT;
    req_bytes = 7'(req_count) << req_size;
    req_cross = ({1'b0, I_ADDR[9:0]} + {4'b0, req_bytes}) > 11'h400;
    req_burst = B_INCR;
    if (!req_cross) begin
      case (req_count)
        5'd1:    req_burst = B_SINGLE;
        5'd4:    req_burst = B_INCR4;
        5'd8:    req_burst = B_INCR8;
        5'd16:   req_burst = B_INCR16;
        default: req_burst = B_INCR;
      endcase
    end
  end

  // Address stepping: the address of the next slot and whether it restarts at a 1 KB page
  always_comb begin
    beat_accepted = HTRANS[1];
    step          = 32'd1 << HSIZE;
    next_addr     = HADDR + step;
    resume_addr   = beat_accepted ? next_addr : HADDR;
    resume_trans  = (resume_addr[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
  end

  // Main FSM with registered address-phase outputs
  always_ff @(posedge HCLK or negedge HRESETN_N) begin
    if (!HRESETN_N) begin
      state      <= S_IDLE;
      HBUSREQ    <= 1'b0;
      HADDR      <= 32'd0;
      HTRANS     <= T_IDLE;
      HWRITE     <= 1'b0;
      HSIZE      <= 3'd0;
      HBURST     <= B_SINGLE;
      HWDATA     <= 32'd0;
      beats_left <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          HTRANS <= T_IDLE;
          HWRITE <= 1'b0;
          if (I_START) begin
            state   <= S_REQ;
            HBUSREQ <= 1'b1;
          end
        end
        S_REQ: begin
          if (HGRANT && HREADY) begin
            state      <= S_ADDR;
            HADDR      <= I_ADDR;
            HSIZE      <= req_size;
            HBURST     <= req_burst;
            HWRITE     <= I_WRITE;
            beats_left <= req_count;
            HTRANS     <= T_NONSEQ;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            if (beat_accepted && HWRITE) begin
              HWDATA <= I_WDATA;
            end
            if (beat_accepted && beats_left == 5'd1) begin
              state   <= S_DATA;
              HTRANS  <= T_IDLE;
              HBUSREQ <= 1'b0;
            end else begin
              if (beat_accepted) begin
                HADDR      <= next_addr;
                beats_left <= beats_left - 5'd1;
              end
              // IDLE inside ADDR means the grant was lost; a regrant restarts as an INCR burst
              if (HTRANS == T_IDLE) begin
                if (HGRANT) begin
                  HTRANS <= T_NONSEQ;
                  HBURST <= B_INCR;
                end
              end else if (!HGRANT) begin
                HTRANS <= T_IDLE;
              end else if (I_BUSY && HBURST != B_SINGLE) begin
                HTRANS <= T_BUSY;
              end else begin
                HTRANS <= resume_trans;
              end
            end
          end
        end
        S_DATA: begin
          if (HREADY) begin
            state  <= S_IDLE;
            HWRITE <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Data-phase tracking and read-data capture
  always_ff @(posedge HCLK or negedge HRESETN_N) begin
    if (!HRESETN_N) begin
      data_ph <= 1'b0;
      O_RDATA <= 32'd0;
    end else begin
      if (data_ph && HREADY && !HWRITE) begin
        O_RDATA <= HRDATA;
      end
      if (HREADY) begin
        data_ph <= (state == S_ADDR) && beat_accepted;
      end
    end
  end

endmodule

// File: tb/tb_ahbif.sv
// tb/tb_ahbif.sv - self-checking bench for ahbif with a burst-level reference model

module tb_ahbif;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETN_N;
  logic        I_START;
  logic [31:0] I_ADDR;
  logic [2:0]  I_SIZE;
  logic [4:0]  I_COUNT;
  logic        I_WRITE;
  logic [31:0] I_WDATA;
  logic        I_BUSY;
  logic        HGRANT;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HBUSREQ;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] O_RDATA;

  int nvec = 0;
  int nerr = 0;

  ahbif dut (
    .HCLK(HCLK), .HRESETN_N(HRESETN_N), .I_START(I_START), .I_ADDR(I_ADDR),
    .I_SIZE(I_SIZE), .I_COUNT(I_COUNT), .I_WRITE(I_WRITE), .I_WDATA(I_WDATA),
    .I_BUSY(I_BUSY), .HGRANT(HGRANT), .HREADY(HREADY), .HRDATA(HRDATA),
    .HBUSREQ(HBUSREQ), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .O_RDATA(O_RDATA)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_size(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  function automatic logic [2:0] m_burst(input logic [31:0] a, input logic [2:0] s, input logic [4:0] n);
    int cc, bytes;
    cc = (n == 5'd0) ? 1 : int'(n);
    bytes = cc << m_size(s);
    if (int'(a[9:0]) + bytes > 1024) return 3'b001;
    case (cc)
      1:       return 3'b000;
      4:       return 3'b011;
      8:       return 3'b101;
      16:      return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hbusreq"}, HBUSREQ, 0);
    chk({tag, "_haddr"}, HADDR, 0);
    chk({tag, "_htrans"}, HTRANS, T_IDLE);
    chk({tag, "_hwrite"}, HWRITE, 0);
    chk({tag, "_hsize"}, HSIZE, 0);
    chk({tag, "_hburst"}, HBURST, 0);
    chk({tag, "_hwdata"}, HWDATA, 0);
    chk({tag, "_o_rdata"}, O_RDATA, 0);
  endtask

  // One transfer against the model: beat list, burst type, kinds, data phases, stalls, BUSY, grant loss
  task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input logic [4:0] count,
                      input logic wr, input int stall_pct, input int busy_pct, input int gl_pct);
    int c, inc, k;
    logic [2:0] burst, esize;
    logic [31:0] ea, dp_wdata, rd_exp, wd, rd;
    logic [1:0] kind, tr;
    logic hr, hg, ib, dp, gl_wait, after_gap, regrant, rd_chk, prev_hr, last_ib, done, beat;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0] s_trans;
    logic [2:0] s_burst, s_size;
    logic s_write;
    esize = m_size(size);
    c = (count == 5'd0) ? 1 : int'(count);
    inc = 1 << esize;
    burst = m_burst(addr, size, count);
    k = 0; dp = 0; gl_wait = 0; after_gap = 0; regrant = 0; rd_chk = 0;
    prev_hr = 1; last_ib = 0; done = 0; rd_exp = 0; dp_wdata = 0;
    s_addr = 0; s_wdata = 0; s_rdata = 0; s_trans = 0; s_burst = 0; s_size = 0; s_write = 0;
    I_START = 1; I_ADDR = addr; I_SIZE = size; I_COUNT = count; I_WRITE = wr;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      tr = HTRANS;
      if (!prev_hr) begin
        chk("hold_haddr", HADDR, s_addr);
        chk("hold_htrans", HTRANS, s_trans);
        chk("hold_hburst", HBURST, s_burst);
        chk("hold_hsize", HSIZE, s_size);
        chk("hold_hwrite", HWRITE, s_write);
        chk("hold_hwdata", HWDATA, s_wdata);
        chk("hold_o_rdata", O_RDATA, s_rdata);
      end
      if (rd_chk) begin
        chk("o_rdata", O_RDATA, rd_exp);
        rd_chk = 0;
      end
      if (cyc > 0) I_START = 0;
      if (k > 0) begin
        I_ADDR = $urandom; I_SIZE = 3'($urandom); I_COUNT = 5'($urandom); I_WRITE = 1'($urandom);
      end
      hr = ($urandom_range(0, 99) >= stall_pct);
      hg = ($urandom_range(0, 99) >= gl_pct);
      ib = ($urandom_range(0, 99) < busy_pct);
      wd = $urandom; rd = $urandom;
      HREADY = hr; HGRANT = hg; I_BUSY = ib; I_WDATA = wd; HRDATA = rd;
      if (dp && hr) begin
        if (wr) chk("hwdata", HWDATA, dp_wdata);
        else begin
          rd_exp = rd;
          rd_chk = 1;
        end
        if (k == c) begin
          chk("last_htrans", tr, T_IDLE);
          chk("last_hbusreq", HBUSREQ, 0);
        end
      end
      beat = (tr == T_NONSEQ || tr == T_SEQ) && hr;
      if (beat) begin
        ea = addr + 32'(k * inc);
        kind = (k == 0 || ea[9:0] == 10'd0 || after_gap) ? T_NONSEQ : T_SEQ;
        chk("beat_haddr", HADDR, ea);
        chk("beat_htrans", tr, kind);
        chk("beat_hburst", HBURST, regrant ? 3'b001 : burst);
        chk("beat_hsize", HSIZE, esize);
        chk("beat_hwrite", HWRITE, wr);
        chk("beat_hbusreq", HBUSREQ, 1);
        chk("beat_in_range", k < c, 1);
        k++;
        after_gap = 0;
        dp_wdata = wd;
      end else if (tr == T_BUSY) begin
        chk("busy_haddr", HADDR, addr + 32'(k * inc));
        chk("busy_cause", last_ib, 1);
        chk("busy_not_first", k > 0, 1);
      end else if (tr == T_IDLE && k > 0 && k < c) begin
        chk("gap_expected", gl_wait, 1);
        chk("gap_hbusreq", HBUSREQ, 1);
      end
      if (hr) begin
        if (gl_wait) begin
          if (hg) begin
            gl_wait = 0;
            after_gap = 1;
            regrant = 1;
          end
        end else if (tr != T_IDLE && !hg && k < c) begin
          gl_wait = 1;
        end
        last_ib = ib;
        if (dp && !beat && k == c) done = 1;
        dp = beat;
      end
      s_addr = HADDR; s_trans = HTRANS; s_burst = HBURST; s_size = HSIZE;
      s_write = HWRITE; s_wdata = HWDATA; s_rdata = O_RDATA;
      prev_hr = hr;
      @(negedge HCLK);
    end
    if (!done) chk("xfer_timeout", 0, 1);
    if (rd_chk) chk("o_rdata_last", O_RDATA, rd_exp);
    chk("end_htrans", HTRANS, T_IDLE);
    chk("end_hbusreq", HBUSREQ, 0);
    chk("end_hwrite", HWRITE, 0);
    HREADY = 1; HGRANT = 1; I_BUSY = 0;
  endtask

  initial begin
    logic [31:0] r, a;
    HRESETN_N = 0; I_START = 1; I_ADDR = 32'h1234; I_SIZE = 2; I_COUNT = 4; I_WRITE = 1;
    I_WDATA = 32'hFFFF; I_BUSY = 0; HGRANT = 1; HREADY = 1; HRDATA = 32'hDEAD;
    @(negedge HCLK); @(negedge HCLK);
    chk_all_zero("reset");
    I_START = 0;
    HRESETN_N = 1;
    @(negedge HCLK);
    chk("post_reset_hbusreq", HBUSREQ, 0);

    // Single write at a page start
    I_START = 1; I_ADDR = 1024; I_SIZE = 0; I_COUNT = 1; I_WRITE = 1; I_WDATA = 64;
    @(negedge HCLK);
    chk("w1_req_hbusreq", HBUSREQ, 1);
    chk("w1_req_htrans", HTRANS, T_IDLE);
    chk("w1_req_hwrite", HWRITE, 0);
    I_START = 0;
    @(negedge HCLK);
    chk("w1_haddr", HADDR, 32'h400);
    chk("w1_htrans", HTRANS, T_NONSEQ);
    chk("w1_hburst", HBURST, 3'b000);
    chk("w1_hwrite", HWRITE, 1);
    chk("w1_hsize", HSIZE, 0);
    @(negedge HCLK);
    I_WDATA = 32'h77;
    chk("w1_hwdata", HWDATA, 64);
    chk("w1_data_htrans", HTRANS, T_IDLE);
    chk("w1_data_hbusreq", HBUSREQ, 0);
    @(negedge HCLK);
    chk("w1_idle_hwrite", HWRITE, 0);
    chk("w1_idle_hwdata", HWDATA, 64);
    chk("w1_idle_hbusreq", HBUSREQ, 0);

    // BUSY inserted after the first beat; I_BUSY high on the first beat is ignored
    I_START = 1; I_ADDR = 0; I_SIZE = 2; I_COUNT = 4; I_WRITE = 0; I_BUSY = 1;
    @(negedge HCLK);
    I_START = 0;
    @(negedge HCLK);
    chk("b_beat0_htrans", HTRANS, T_NONSEQ);
    chk("b_beat0_haddr", HADDR, 0);
    chk("b_hburst", HBURST, 3'b011);
    @(negedge HCLK);
    chk("b_busy_htrans", HTRANS, T_BUSY);
    chk("b_busy_haddr", HADDR, 4);
    I_BUSY = 0;
    for (int i = 1; i < 4; i++) begin
      @(negedge HCLK);
      chk("b_seq_htrans", HTRANS, T_SEQ);
      chk("b_seq_haddr", HADDR, 32'(4 * i));
    end
    @(negedge HCLK);
    chk("b_done_htrans", HTRANS, T_IDLE);
    chk("b_done_hbusreq", HBUSREQ, 0);
    @(negedge HCLK);

    // Directed bursts through the model
    xfer(32'd1022, 3'd0, 5'd4, 1'b1, 0, 0, 0);
    xfer(32'h3FC, 3'd2, 5'd4, 1'b1, 0, 0, 0);
    xfer(32'h0, 3'd2, 5'd4, 1'b0, 0, 0, 0);
    xfer(32'd12, 3'd3, 5'd8, 1'b1, 0, 0, 0);
    xfer(32'h40, 3'd2, 5'd4, 1'b0, 35, 0, 0);
    xfer(32'h80, 3'd1, 5'd16, 1'b1, 30, 0, 0);
    xfer(32'hFFFFFFFE, 3'd1, 5'd4, 1'b0, 0, 0, 0);
    xfer(32'h3FF, 3'd0, 5'd0, 1'b1, 0, 0, 0);
    xfer(32'h200, 3'd2, 5'd8, 1'b1, 0, 30, 0);
    xfer(32'h300, 3'd2, 5'd8, 1'b0, 10, 0, 30);

    // Random bursts, alternating stress mixes
    for (int t = 0; t < 30; t++) begin
      r = $urandom;
      a = $urandom;
      if (r[0]) a[9:0] = 10'h3C0 + 10'(r[6:1]);
      case (t % 3)
        0: xfer(a, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 16)), 1'($urandom), 25, 0, 0);
        1: xfer(a, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 16)), 1'($urandom), 15, 25, 0);
        default: xfer(a, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 16)), 1'($urandom), 15, 0, 25);
      endcase
    end

    // Reset in the middle of a burst aborts at once
    I_START = 1; I_ADDR = 32'h100; I_SIZE = 2; I_COUNT = 8; I_WRITE = 1; I_WDATA = 32'hA5A5;
    HGRANT = 1; HREADY = 1; I_BUSY = 0;
    @(negedge HCLK);
    I_START = 0;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("rst_mid_haddr", HADDR, 32'h104);
    HRESETN_N = 0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge HCLK);
    chk_all_zero("rst_hold");
    HRESETN_N = 1;
    @(negedge HCLK);
    chk("rst_after_htrans", HTRANS, T_IDLE);
    chk("rst_after_hbusreq", HBUSREQ, 0);
    chk("rst_after_haddr", HADDR, 0);
    xfer(32'h500, 3'd2, 5'd4, 1'b0, 20, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
